// File: rtl/tlb_mmu.sv
// tlb_mmu: 16-entry fully associative MIPS32 joint TLB (MMU side of CP0/MMU bus).
//
// Stores entries written by CP0 (TLBWI/TLBWR), answers TLBR reads and TLBP
// probes, and translates one fetch address and one data address per cycle.
// All results are registered one cycle after the request/command.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   CP0_*                       entry fields, current ASID and target index
//   tlbwi/tlbwr/tlbr/tlbp       single-cycle command pulses
//   Rd_*, Rd_valid              TLBR result (Rd_g feeds both CP0 g0 and g1)
//   Probe_Index/Miss/valid      TLBP result
//   I_req/I_vaddr -> I_*        fetch translation
//   D_req/D_vaddr/D_store -> D_* data translation
//
// Build option: TLB_RANDOM_EN -- when defined, TLBWR writes the entry selected
// by a free-running Random counter (reset 15, decrements every cycle);
// otherwise TLBWR writes at CP0_Index like TLBWI.

module tlb_mmu #(
    parameter int ENTRIES = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [18:0]                 CP0_vpn2,
    input  logic [7:0]                  CP0_asid,
    input  logic [19:0]                 CP0_pfn0,
    input  logic [2:0]                  CP0_c0,
    input  logic                        CP0_d0,
    input  logic                        CP0_v0,
    input  logic                        CP0_g0,
    input  logic [19:0]                 CP0_pfn1,
    input  logic [2:0]                  CP0_c1,
    input  logic                        CP0_d1,
    input  logic                        CP0_v1,
    input  logic                        CP0_g1,
    input  logic [$clog2(ENTRIES)-1:0]  CP0_Index,
    input  logic                        tlbwi,
    input  logic                        tlbwr,
    input  logic                        tlbr,
    input  logic                        tlbp,
    output logic [18:0]                 Rd_vpn2,
    output logic [7:0]                  Rd_asid,
    output logic [19:0]                 Rd_pfn0,
    output logic [2:0]                  Rd_c0,
    output logic                        Rd_d0,
    output logic                        Rd_v0,
    output logic [19:0]                 Rd_pfn1,
    output logic [2:0]                  Rd_c1,
    output logic                        Rd_d1,
    output logic                        Rd_v1,
    output logic                        Rd_g,
    output logic                        Rd_valid,
    output logic [$clog2(ENTRIES)-1:0]  Probe_Index,
    output logic                        Probe_Miss,
    output logic                        Probe_valid,
    input  logic                        I_req,
    input  logic [31:0]                 I_vaddr,
    output logic [31:0]                 I_paddr,
    output logic                        I_uncached,
    output logic                        I_Refill,
    output logic                        I_Invalid,
    output logic                        I_valid,
    input  logic                        D_req,
    input  logic [31:0]                 D_vaddr,
    input  logic                        D_store,
    output logic [31:0]                 D_paddr,
    output logic                        D_uncached,
    output logic                        D_Refill,
    output logic                        D_Invalid,
    output logic                        D_Modified,
    output logic                        D_valid
);

    localparam int IW = $clog2(ENTRIES);

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } entry_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        uncached;
        logic        refill;
        logic        invalid;
        logic        modified;
    } xlat_t;

    entry_t tlb_q [ENTRIES];

    // Returns {found, index}; scanning downwards leaves the lowest hit.
    function automatic logic [IW:0] first_hit(input logic [ENTRIES-1:0] hit);
        first_hit = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (hit[i]) first_hit = {1'b1, IW'(i)};
        end
    endfunction

    function automatic xlat_t translate(input logic [31:0] va, input logic store,
                                        input logic found, input entry_t e);
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        pfn = va[12] ? e.pfn1 : e.pfn0;
        c   = va[12] ? e.c1   : e.c0;
        d   = va[12] ? e.d1   : e.d0;
        v   = va[12] ? e.v1   : e.v0;
        translate = '0;
        if (va[31:30] == 2'b10) begin
            // kseg0/kseg1: unmapped, bit 29 distinguishes uncached kseg1
            translate.paddr    = {3'b000, va[28:0]};
            translate.uncached = va[29];
        end else if (!found) begin
            translate.refill = 1'b1;
        end else if (!v) begin
            translate.invalid = 1'b1;
        end else if (store && !d) begin
            translate.modified = 1'b1;
        end else begin
            translate.paddr    = {pfn, va[11:0]};
            translate.uncached = (c == 3'd2);
        end
    endfunction

    logic [ENTRIES-1:0] i_hit, d_hit, p_hit;
    logic [IW:0]        i_sel, d_sel, p_sel;
    entry_t             i_ent, d_ent, rd_ent, new_ent;
    xlat_t              i_xlat, d_xlat;
    logic               do_wr, do_rd, do_pr;
    logic [IW-1:0]      wr_idx;

    always_comb begin
        i_hit = '0;
        d_hit = '0;
        p_hit = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            i_hit[i] = (tlb_q[i].vpn2 == I_vaddr[31:13]) &&
                       (tlb_q[i].g || tlb_q[i].asid == CP0_asid);
            d_hit[i] = (tlb_q[i].vpn2 == D_vaddr[31:13]) &&
                       (tlb_q[i].g || tlb_q[i].asid == CP0_asid);
            p_hit[i] = (tlb_q[i].vpn2 == CP0_vpn2) &&
                       (tlb_q[i].g || tlb_q[i].asid == CP0_asid);
        end
    end

    assign i_sel  = first_hit(i_hit);
    assign d_sel  = first_hit(d_hit);
    assign p_sel  = first_hit(p_hit);
    assign i_ent  = tlb_q[i_sel[IW-1:0]];
    assign d_ent  = tlb_q[d_sel[IW-1:0]];
    assign rd_ent = tlb_q[CP0_Index];
    assign i_xlat = translate(I_vaddr, 1'b0, i_sel[IW], i_ent);
    assign d_xlat = translate(D_vaddr, D_store, d_sel[IW], d_ent);

    // Overlapping pulses are illegal; lower-priority ones are simply dropped.
    assign do_wr = tlbwi | tlbwr;
    assign do_rd = tlbr & ~do_wr;
    assign do_pr = tlbp & ~do_wr & ~tlbr;

    assign new_ent = '{vpn2: CP0_vpn2, asid: CP0_asid, g: CP0_g0 & CP0_g1,
                       pfn0: CP0_pfn0, c0: CP0_c0, d0: CP0_d0, v0: CP0_v0,
                       pfn1: CP0_pfn1, c1: CP0_c1, d1: CP0_d1, v1: CP0_v1};

`ifdef TLB_RANDOM_EN
    logic [IW-1:0] random_q;

    always_ff @(posedge clk) begin
        if (!resetn) random_q <= '1;
        else         random_q <= random_q - IW'(1);
    end

    assign wr_idx = tlbwi ? CP0_Index : random_q;
`else
    assign wr_idx = CP0_Index;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) tlb_q[i] <= '0;
            {Rd_vpn2, Rd_asid, Rd_g}             <= '0;
            {Rd_pfn0, Rd_c0, Rd_d0, Rd_v0}       <= '0;
            {Rd_pfn1, Rd_c1, Rd_d1, Rd_v1}       <= '0;
            Rd_valid    <= 1'b0;
            Probe_Index <= '0;
            Probe_Miss  <= 1'b0;
            Probe_valid <= 1'b0;
            I_paddr     <= '0;
            I_uncached  <= 1'b0;
            I_Refill    <= 1'b0;
            I_Invalid   <= 1'b0;
            I_valid     <= 1'b0;
            D_paddr     <= '0;
            D_uncached  <= 1'b0;
            D_Refill    <= 1'b0;
            D_Invalid   <= 1'b0;
            D_Modified  <= 1'b0;
            D_valid     <= 1'b0;
        end else begin
            if (do_wr) tlb_q[wr_idx] <= new_ent;

            I_valid <= I_req;
            if (I_req) begin
                I_paddr    <= i_xlat.paddr;
                I_uncached <= i_xlat.uncached;
                I_Refill   <= i_xlat.refill;
                I_Invalid  <= i_xlat.invalid;
            end

            D_valid <= D_req;
            if (D_req) begin
                D_paddr    <= d_xlat.paddr;
                D_uncached <= d_xlat.uncached;
                D_Refill   <= d_xlat.refill;
                D_Invalid  <= d_xlat.invalid;
                D_Modified <= d_xlat.modified;
            end

            Rd_valid <= do_rd;
            if (do_rd) begin
                Rd_vpn2 <= rd_ent.vpn2;
                Rd_asid <= rd_ent.asid;
                Rd_g    <= rd_ent.g;
                Rd_pfn0 <= rd_ent.pfn0;
                Rd_c0   <= rd_ent.c0;
                Rd_d0   <= rd_ent.d0;
                Rd_v0   <= rd_ent.v0;
                Rd_pfn1 <= rd_ent.pfn1;
                Rd_c1   <= rd_ent.c1;
                Rd_d1   <= rd_ent.d1;
                Rd_v1   <= rd_ent.v1;
            end

            Probe_valid <= do_pr;
            if (do_pr) begin
                Probe_Index <= p_sel[IW-1:0];
                Probe_Miss  <= ~p_sel[IW];
            end
        end
    end

endmodule

// File: tb/tb_tlb_mmu.sv
module tb_tlb_mmu;

    logic        clk = 1'b0;
    logic        resetn;
    logic [18:0] CP0_vpn2;
    logic [7:0]  CP0_asid;
    logic [19:0] CP0_pfn0, CP0_pfn1;
    logic [2:0]  CP0_c0, CP0_c1;
    logic        CP0_d0, CP0_v0, CP0_g0, CP0_d1, CP0_v1, CP0_g1;
    logic [3:0]  CP0_Index;
    logic        tlbwi, tlbwr, tlbr, tlbp;
    logic [18:0] Rd_vpn2;
    logic [7:0]  Rd_asid;
    logic [19:0] Rd_pfn0, Rd_pfn1;
    logic [2:0]  Rd_c0, Rd_c1;
    logic        Rd_d0, Rd_v0, Rd_d1, Rd_v1, Rd_g, Rd_valid;
    logic [3:0]  Probe_Index;
    logic        Probe_Miss, Probe_valid;
    logic        I_req, D_req, D_store;
    logic [31:0] I_vaddr, D_vaddr, I_paddr, D_paddr;
    logic        I_uncached, I_Refill, I_Invalid, I_valid;
    logic        D_uncached, D_Refill, D_Invalid, D_Modified, D_valid;

    tlb_mmu dut (
        .clk(clk), .resetn(resetn),
        .CP0_vpn2(CP0_vpn2), .CP0_asid(CP0_asid),
        .CP0_pfn0(CP0_pfn0), .CP0_c0(CP0_c0), .CP0_d0(CP0_d0), .CP0_v0(CP0_v0), .CP0_g0(CP0_g0),
        .CP0_pfn1(CP0_pfn1), .CP0_c1(CP0_c1), .CP0_d1(CP0_d1), .CP0_v1(CP0_v1), .CP0_g1(CP0_g1),
        .CP0_Index(CP0_Index),
        .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbr(tlbr), .tlbp(tlbp),
        .Rd_vpn2(Rd_vpn2), .Rd_asid(Rd_asid),
        .Rd_pfn0(Rd_pfn0), .Rd_c0(Rd_c0), .Rd_d0(Rd_d0), .Rd_v0(Rd_v0),
        .Rd_pfn1(Rd_pfn1), .Rd_c1(Rd_c1), .Rd_d1(Rd_d1), .Rd_v1(Rd_v1),
        .Rd_g(Rd_g), .Rd_valid(Rd_valid),
        .Probe_Index(Probe_Index), .Probe_Miss(Probe_Miss), .Probe_valid(Probe_valid),
        .I_req(I_req), .I_vaddr(I_vaddr), .I_paddr(I_paddr), .I_uncached(I_uncached),
        .I_Refill(I_Refill), .I_Invalid(I_Invalid), .I_valid(I_valid),
        .D_req(D_req), .D_vaddr(D_vaddr), .D_store(D_store), .D_paddr(D_paddr),
        .D_uncached(D_uncached), .D_Refill(D_Refill), .D_Invalid(D_Invalid),
        .D_Modified(D_Modified), .D_valid(D_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } ent_t;

    ent_t        tlb [16];
    ent_t        e_rd;
    int          n_checks = 0;
    int          n_errors = 0;
    int          rel_cnt  = 0;
    logic        e_iv, e_dv, e_rv, e_pv, e_pmiss, pidx_known;
    logic [3:0]  e_pidx;
    logic [31:0] e_ipa, e_dpa;
    logic        e_iu, e_ir, e_ii, e_im, e_du, e_dr, e_di, e_dm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int find(input logic [18:0] vpn2, input logic [7:0] asid);
        for (int i = 0; i < 16; i++)
            if (tlb[i].vpn2 == vpn2 && (tlb[i].g || tlb[i].asid == asid)) return i;
        return -1;
    endfunction

    task automatic model_xlat(input logic [31:0] va, input logic st,
                              output logic [31:0] pa, output logic unc,
                              output logic rf, output logic inv, output logic md);
        int   k;
        ent_t e;
        logic odd;
        pa = 0; unc = 0; rf = 0; inv = 0; md = 0;
        if (va >= 32'h8000_0000 && va <= 32'hBFFF_FFFF) begin
            pa  = va & 32'h1FFF_FFFF;
            unc = (va >= 32'hA000_0000);
        end else begin
            k = find(va[31:13], CP0_asid);
            if (k < 0) rf = 1;
            else begin
                e   = tlb[k];
                odd = va[12];
                if (!(odd ? e.v1 : e.v0)) inv = 1;
                else if (st && !(odd ? e.d1 : e.d0)) md = 1;
                else begin
                    pa  = {(odd ? e.pfn1 : e.pfn0), va[11:0]};
                    unc = ((odd ? e.c1 : e.c0) == 3'd2);
                end
            end
        end
    endtask

    // Compute expectations from inputs and the model, advance one clock, compare.
    task automatic step();
        int   k;
        int   widx;
        ent_t ne;
        if (!resetn) begin
            for (int i = 0; i < 16; i++) tlb[i] = '0;
            e_rd = '0; e_pidx = 0; pidx_known = 1; e_pmiss = 0;
            e_iv = 0; e_dv = 0; e_rv = 0; e_pv = 0;
            rel_cnt = 0;
        end else begin
            e_iv = I_req;
            if (I_req) model_xlat(I_vaddr, 1'b0, e_ipa, e_iu, e_ir, e_ii, e_im);
            e_dv = D_req;
            if (D_req) model_xlat(D_vaddr, D_store, e_dpa, e_du, e_dr, e_di, e_dm);
            e_rv = 0; e_pv = 0;
            if (tlbwi || tlbwr) begin
`ifdef TLB_RANDOM_EN
                widx = tlbwi ? int'(CP0_Index) : ((15 - rel_cnt) % 16 + 16) % 16;
`else
                widx = int'(CP0_Index);
`endif
                ne = '{vpn2: CP0_vpn2, asid: CP0_asid, g: CP0_g0 & CP0_g1,
                       pfn0: CP0_pfn0, c0: CP0_c0, d0: CP0_d0, v0: CP0_v0,
                       pfn1: CP0_pfn1, c1: CP0_c1, d1: CP0_d1, v1: CP0_v1};
                tlb[widx] = ne;
            end else if (tlbr) begin
                e_rv = 1;
                e_rd = tlb[CP0_Index];
            end else if (tlbp) begin
                e_pv = 1;
                k = find(CP0_vpn2, CP0_asid);
                e_pmiss = (k < 0);
                pidx_known = (k >= 0);
                if (k >= 0) e_pidx = 4'(k);
            end
            rel_cnt++;
        end
        @(posedge clk);
        #1;
        check("I_valid", I_valid, e_iv);
        if (e_iv) begin
            check("I_paddr", I_paddr, e_ipa);
            check("I_Refill", I_Refill, e_ir);
            check("I_Invalid", I_Invalid, e_ii);
            if (!e_ir && !e_ii) check("I_uncached", I_uncached, e_iu);
        end
        check("D_valid", D_valid, e_dv);
        if (e_dv) begin
            check("D_paddr", D_paddr, e_dpa);
            check("D_Refill", D_Refill, e_dr);
            check("D_Invalid", D_Invalid, e_di);
            check("D_Modified", D_Modified, e_dm);
            if (!e_dr && !e_di && !e_dm) check("D_uncached", D_uncached, e_du);
        end
        check("Rd_valid", Rd_valid, e_rv);
        check("Rd_vpn2", Rd_vpn2, e_rd.vpn2);
        check("Rd_asid", Rd_asid, e_rd.asid);
        check("Rd_g", Rd_g, e_rd.g);
        check("Rd_page0", {Rd_pfn0, Rd_c0, Rd_d0, Rd_v0}, {e_rd.pfn0, e_rd.c0, e_rd.d0, e_rd.v0});
        check("Rd_page1", {Rd_pfn1, Rd_c1, Rd_d1, Rd_v1}, {e_rd.pfn1, e_rd.c1, e_rd.d1, e_rd.v1});
        check("Probe_valid", Probe_valid, e_pv);
        check("Probe_Miss", Probe_Miss, e_pmiss);
        if (pidx_known) check("Probe_Index", Probe_Index, e_pidx);
    endtask

    task automatic idle();
        tlbwi = 0; tlbwr = 0; tlbr = 0; tlbp = 0;
        I_req = 0; D_req = 0; D_store = 0;
    endtask

    task automatic set_ent(input logic [18:0] vpn2, input logic [7:0] asid,
                           input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
                           input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1,
                           input logic g);
        CP0_vpn2 = vpn2; CP0_asid = asid;
        CP0_pfn0 = pfn0; CP0_c0 = c0; CP0_d0 = d0; CP0_v0 = v0;
        CP0_pfn1 = pfn1; CP0_c1 = c1; CP0_d1 = d1; CP0_v1 = v1;
        CP0_g0 = g; CP0_g1 = g;
    endtask

    function automatic logic [18:0] pool_vpn2(input int k);
        case (k)
            0:       return 19'h00200;
            1:       return 19'h00201;
            2:       return 19'h7FFFF;
            default: return 19'h60001;
        endcase
    endfunction

    function automatic logic [31:0] rand_va();
        case ($urandom_range(0, 2))
            0:       return {pool_vpn2(int'($urandom_range(0, 3))), 13'($urandom)};
            1:       return {2'b10, 30'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        idle();
        set_ent(19'h0, 8'h0, 20'h0, 3'd0, 0, 0, 20'h0, 3'd0, 0, 0, 0);
        CP0_Index = 0; I_vaddr = 0; D_vaddr = 0;
        resetn = 0;
        step();
        step();
        check("rst_D_paddr", D_paddr, 32'h0);
        check("rst_I_paddr", I_paddr, 32'h0);

        // First cycle after reset release: unmapped-by-TLB address misses.
        resetn = 1;
        D_req = 1; D_vaddr = 32'h0040_0000;
        step();
        check("tp_refill_valid", D_valid, 1);
        check("tp_refill_flag", D_Refill, 1);
        check("tp_refill_paddr", D_paddr, 32'h0);
        idle();
        repeat (4) step();

        // TLBWR five cycles after release.
        set_ent(19'h11111, 8'h00, 20'hAAAAA, 3'd3, 1, 1, 20'hBBBBB, 3'd3, 1, 1, 1);
        CP0_Index = 4'd7;
        tlbwr = 1;
        step();
        idle();
`ifdef TLB_RANDOM_EN
        CP0_Index = 4'd10;
`else
        CP0_Index = 4'd7;
`endif
        tlbr = 1;
        step();
        check("tp_tlbwr_vpn2", Rd_vpn2, 19'h11111);
        idle();

        set_ent(19'h00200, 8'h05, 20'h12345, 3'd3, 1, 1, 20'h54321, 3'd2, 1, 0, 0);
        CP0_Index = 4'd3;
        tlbwi = 1;
        step();
        idle();
        D_req = 1; D_vaddr = 32'h0040_0ABC;
        step();
        check("tp_map_paddr", D_paddr, 32'h1234_5ABC);
        check("tp_map_uncached", D_uncached, 0);
        check("tp_map_flags", {D_Refill, D_Invalid, D_Modified}, 3'b000);

        idle();
        CP0_d0 = 0; tlbwi = 1;
        step();
        idle();
        D_req = 1; D_store = 1; D_vaddr = 32'h0040_0ABC;
        step();
        check("tp_modified", D_Modified, 1);
        D_store = 0; D_vaddr = 32'h0040_1000;
        step();
        check("tp_invalid", D_Invalid, 1);
        CP0_asid = 8'h06; D_vaddr = 32'h0040_0ABC;
        step();
        check("tp_asid_refill", D_Refill, 1);
        idle();
        CP0_asid = 8'h05;

        I_req = 1; I_vaddr = 32'hBFC0_0000;
        step();
        check("tp_kseg1_paddr", I_paddr, 32'h1FC0_0000);
        check("tp_kseg1_unc", I_uncached, 1);
        I_vaddr = 32'h8000_0100;
        step();
        check("tp_kseg0_paddr", I_paddr, 32'h0000_0100);
        check("tp_kseg0_unc", I_uncached, 0);
        idle();

        CP0_vpn2 = 19'h00200; tlbp = 1;
        step();
        check("tp_probe_idx", Probe_Index, 4'd3);
        check("tp_probe_hit", Probe_Miss, 0);
        CP0_vpn2 = 19'h7FFFF;
        step();
        check("tp_probe_miss", Probe_Miss, 1);
        idle();
        CP0_Index = 4'd3; tlbr = 1;
        step();
        check("tp_tlbr_pfn0", Rd_pfn0, 20'h12345);
        // tlbr outranks tlbp: only the read strobe fires.
        tlbp = 1;
        step();
        check("tp_prio_probe", Probe_valid, 0);
        idle();

        for (int n = 0; n < 3000; n++) begin
            resetn   = ($urandom_range(0, 199) != 0);
            CP0_vpn2 = pool_vpn2(int'($urandom_range(0, 3)));
            CP0_asid = ($urandom_range(0, 1) != 0) ? 8'h05 : 8'h06;
            CP0_pfn0 = 20'($urandom); CP0_c0 = 3'($urandom);
            CP0_d0   = 1'($urandom);  CP0_v0 = 1'($urandom);
            CP0_pfn1 = 20'($urandom); CP0_c1 = 3'($urandom);
            CP0_d1   = 1'($urandom);  CP0_v1 = 1'($urandom);
            CP0_g0   = 1'($urandom);  CP0_g1 = 1'($urandom);
            CP0_Index = 4'($urandom);
            tlbwi = ($urandom_range(0, 5) == 0);
            tlbwr = ($urandom_range(0, 5) == 0);
            tlbr  = ($urandom_range(0, 4) == 0);
            tlbp  = ($urandom_range(0, 4) == 0);
            I_req = 1'($urandom); I_vaddr = rand_va();
            D_req = 1'($urandom); D_vaddr = rand_va(); D_store = 1'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tlb_mmu.md
# tlb_mmu

Sixteen-entry, fully associative MIPS32 joint TLB: the MMU-side endpoint of the CP0/MMU entry bus. It stores entries written by CP0 on TLBWI/TLBWR, returns entries for TLBR and match indices for TLBP, and translates one instruction-fetch address and one data address per cycle with registered results. It sits between CP0, which drives entry fields and commands from the WB stage, and the IF and MEM stages, which consume translated addresses and TLB exception flags.

## Interface
- ENTRIES, 16: number of entries; index width is log2(ENTRIES) = 4
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- CP0_vpn2, CP0_asid, CP0_pfn0/c0/d0/v0/g0, CP0_pfn1/c1/d1/v1/g1, CP0_Index  in  19/8/20/3/1/1/1/20/3/1/1/1/4  entry fields and target index from CP0
- tlbwi, tlbwr, tlbr, tlbp  in  1 each  single-cycle command pulses from CP0
- Rd_vpn2, Rd_asid, Rd_pfn0/c0/d0/v0, Rd_pfn1/c1/d1/v1, Rd_g  out  matching widths  TLBR result; g is driven to both CP0 g0 and g1
- Rd_valid  out  1  TLBR result strobe
- Probe_Index  out  4  TLBP matching index
- Probe_Miss  out  1  TLBP found no match; CP0 sets Index.P
- Probe_valid  out  1  TLBP result strobe
- I_req, I_vaddr  in  1, 32  fetch lookup request
- I_paddr, I_uncached, I_Refill, I_Invalid  out  32, 1, 1, 1  fetch result
- D_req, D_vaddr, D_store  in  1, 32, 1  data lookup; D_store = 1 for store
- D_paddr, D_uncached, D_Refill, D_Invalid, D_Modified  out  32, 1, 1, 1, 1  data result
- D_valid, I_valid  out  1 each  result strobes

## Operation
- Entry layout: vpn2[18:0], asid[7:0], G, then pfn/c/d/v for each of the two pages. On write, G = CP0_g0 & CP0_g1.
- TLBWI writes the entry at CP0_Index. TLBWR writes the entry at the Random counter.
- Random counter: 4 bits, reset value 15. It decrements every cycle and wraps from 0 to 15.
- Match condition: entry.vpn2 == vaddr[31:13] && (entry.G || entry.asid == CP0_asid). vaddr[12] selects page 1 (even/odd pair).
- Multiple matches are illegal software, but behaviour is defined: the lowest index wins.
- Segments:
  - kseg0 (0x8000_0000–0x9FFF_FFFF): paddr = vaddr & 0x1FFF_FFFF, cached.
  - kseg1 (0xA000_0000–0xBFFF_FFFF): paddr = vaddr & 0x1FFF_FFFF, uncached.
  - Unmapped segments never raise TLB flags.
  - Mapped segments: paddr = {pfn, vaddr[11:0]}; uncached = (c == 3'd2).
- Mapped exceptions, mutually exclusive, in priority order:
  - No match → Refill.
  - Match with v = 0 → Invalid.
  - D_store = 1, v = 1, d = 0 → Modified.
  - On any flag, paddr is 0.
- TLBP compares CP0_vpn2/CP0_asid against all entries. TLBR reads the entry at CP0_Index.
- Simultaneous command pulses are illegal. Required priority: tlbwi > tlbwr > tlbr > tlbp; lower-priority pulses are dropped.

## Timing
- Reset: every entry is zeroed (v0 = v1 = 0). Random = 15. All outputs and strobes are 0.
- Writes take effect at the clock edge of the command cycle. A lookup, TLBP or TLBR in the same cycle sees the old contents; the next cycle sees the new entry.
- Lookups: latency 1. Result and *_valid are registered one cycle after the req cycle; *_valid is high for exactly one cycle. I and D ports are independent and may both be requested every cycle, fully pipelined.
- TLBR and TLBP: result plus strobe arrive one cycle after the pulse. Result registers hold their value until the next command of the same kind.
- resetn low during any cycle discards in-flight results: no strobe the following cycle.

## Configuration
- TLB_RANDOM_EN defined: TLBWR uses the Random counter as described above.
- TLB_RANDOM_EN undefined: no Random counter; TLBWR writes at CP0_Index, identical to TLBWI.

## Test plan
- Reset, then D_req at 0x0040_0000 → next cycle D_valid = 1, D_Refill = 1, D_paddr = 0.
- TLBWI, Index 3, vpn2 = 0x00200, asid 0x05, pfn0 = 0x12345, v0 = 1, d0 = 1, c0 = 3. Next cycle D_req at 0x0040_0ABC with asid 5 → D_paddr = 0x1234_5ABC, D_uncached = 0, no flags.
- Same entry with d0 = 0, D_store = 1 → D_Modified = 1. Same entry with v1 = 0, vaddr 0x0040_1000 → D_Invalid = 1. Change CP0_asid to 6 with G = 0 → D_Refill = 1.
- I_req at 0xBFC0_0000 → I_paddr = 0x1FC0_0000, I_uncached = 1. I_req at 0x8000_0100 → I_paddr = 0x0000_0100, I_uncached = 0.
- TLBP for vpn2 0x00200 → Probe_Index = 3, Probe_Miss = 0. TLBP for vpn2 0x7FFFF → Probe_Miss = 1. TLBR at Index 3 → Rd_pfn0 = 0x12345.
- With TLB_RANDOM_EN: TLBWR issued 5 cycles after reset release writes index 10. Without TLB_RANDOM_EN: TLBWR writes CP0_Index.
